// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the regfile command sequencer.
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_COPY  = 2'b10,
    OP_SWAP  = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } seq_state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Master-side sequencer for the 8x16 regfile: executes one WRITE/READ/COPY/SWAP
// command at a time through the regfile's combinational read and edge write.
//
// state | meaning
// IDLE  | ready for a command; fields latched on acceptance
// RD_A  | readnum = ra, capture tmp_a (and rd_data for READ)
// RD_B  | readnum = rb, capture tmp_b
// WR_A  | write ra with imm (WRITE) or tmp_b (COPY/SWAP)
// WR_B  | write rb with tmp_a (SWAP second half)
// DONE  | one-cycle done pulse, not ready
import regfile_seq_pkg::*;

module regfile_sequencer #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_ra,
  input  logic [IDX_W-1:0]  cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [IDX_W-1:0]  rf_writenum,
  output logic              rf_write,
  output logic [IDX_W-1:0]  rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out
);

  seq_state_t        state, state_nxt;
  cmd_op_t           op;
  logic [IDX_W-1:0]  ra, rb;
  logic [DATA_W-1:0] imm, tmp_a, tmp_b;

  logic accept;
  assign accept = (state == IDLE) && cmd_valid;

  // State register; async reset drops every decoded output at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command fields, read captures and READ result.
  // rd_data takes the bus value directly in RD_A because tmp_a is loaded on
  // that same edge and would otherwise be one command stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op      <= OP_WRITE;
      ra      <= '0;
      rb      <= '0;
      imm     <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        op  <= cmd_op_t'(cmd_op);
        ra  <= cmd_ra;
        rb  <= cmd_rb;
        imm <= cmd_imm;
      end
      if (state == RD_A) begin
        tmp_a <= rf_data_out;
        if (op == OP_READ) rd_data <= rf_data_out;
      end
      if (state == RD_B) tmp_b <= rf_data_out;
    end
  end

  // Next-state sequencing per opcode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_t'(cmd_op))
            OP_WRITE: state_nxt = WR_A;
            OP_READ:  state_nxt = RD_A;
            OP_COPY:  state_nxt = RD_B;
            OP_SWAP:  state_nxt = RD_A;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      RD_A:    state_nxt = (op == OP_READ) ? DONE : RD_B;
      RD_B:    state_nxt = WR_A;
      WR_A:    state_nxt = (op == OP_SWAP) ? WR_B : DONE;
      WR_B:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Regfile port and handshake decode from state and latched fields only.
  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_data_in  = '0;
    rf_readnum  = '0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      RD_A: rf_readnum = ra;
      RD_B: rf_readnum = rb;
      WR_A: begin
        rf_write    = 1'b1;
        rf_writenum = ra;
        rf_data_in  = (op == OP_WRITE) ? imm : tmp_b;
      end
      WR_B: begin
        rf_write    = 1'b1;
        rf_writenum = rb;
        rf_data_in  = tmp_a;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural 8x16 regfile as the slave.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic        clk = 0;
  logic        reset = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 0;
  logic [2:0]  cmd_ra = 0, cmd_rb = 0;
  logic [15:0] cmd_imm = 0;
  logic        done;
  logic [15:0] rd_data, rf_data_in, rf_data_out;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .done(done), .rd_data(rd_data), .rf_data_in(rf_data_in),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_readnum(rf_readnum),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // slave regfile: one write per rising edge, combinational read
  logic [15:0] rf_mem [8];
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_readnum];

  // reference model and scoreboard
  typedef struct { logic [15:0] rd; int lat; } exp_t;
  exp_t        sb[$];
  logic [15:0] mrf [8];
  logic [15:0] mrd;
  int tests = 0, fails = 0;
  int cyc = 0, acc_n = 0;

  // monitor: acceptance seen at a negedge happens on the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (cmd_valid && cmd_ready) acc_n = cyc;
    if (done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        tests++;
        if (rd_data !== e.rd) begin
          fails++;
          $display("FAIL rd_data got %h expected %h", rd_data, e.rd);
        end
        tests++;
        if (cyc - acc_n !== e.lat) begin
          fails++;
          $display("FAIL latency got %0d expected %0d", cyc - acc_n, e.lat);
        end
      end
    end
    cyc++;
  end

  function automatic int model_cmd(input logic [1:0] op, input logic [2:0] ra,
                                   input logic [2:0] rb, input logic [15:0] imm);
    logic [15:0] t;
    case (op)
      2'b00: begin mrf[ra] = imm; return 2; end
      2'b01: begin mrd = mrf[ra]; return 2; end
      2'b10: begin mrf[ra] = mrf[rb]; return 3; end
      default: begin t = mrf[ra]; mrf[ra] = mrf[rb]; mrf[rb] = t; return 5; end
    endcase
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 40 && !cmd_ready; i++) begin @(posedge clk); #1; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout got %b expected 1", cmd_ready);
    end
  endtask

  // returns #1 after the accepting edge
  task automatic send(input logic [1:0] op, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [15:0] imm, input bit score);
    exp_t e;
    int   lat;
    wait_ready();
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_valid = 1;
    lat = model_cmd(op, ra, rb, imm);
    e.rd = mrd; e.lat = lat;
    if (score) sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || !cmd_ready); i++) begin @(posedge clk); #1; end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout pending %0d expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1; #12;
    for (int i = 0; i < 8; i++) begin rf_mem[i] = 0; mrf[i] = 0; end
    mrd = 0; sb.delete();
    tests++;
    if ({cmd_ready, done, rf_write} !== 3'b100) begin
      fails++; $display("FAIL reset_ctrl got %b expected 100", {cmd_ready, done, rf_write});
    end
    tests++;
    if ({rd_data, rf_data_in, rf_writenum, rf_readnum} !== 38'd0) begin
      fails++; $display("FAIL reset_data got %h expected 0", {rd_data, rf_data_in, rf_writenum, rf_readnum});
    end
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_write_read();
    send(2'b00, 3'd0, 3'd0, 16'h00AA, 1);
    tests++;
    if ({cmd_ready, rf_write, rf_writenum, rf_data_in} !== {1'b0, 1'b1, 3'd0, 16'h00AA}) begin
      fails++; $display("FAIL write_port got %b/%b/%0d/%h expected 0/1/0/00aa",
                        cmd_ready, rf_write, rf_writenum, rf_data_in);
    end
    @(posedge clk); #1;
    tests++;
    if (rf_write !== 1'b0) begin
      fails++; $display("FAIL write_pulse_len got %b expected 0", rf_write);
    end
    send(2'b01, 3'd0, 3'd0, 16'h0, 1);
    drain();
  endtask

  task automatic test_copy();
    send(2'b00, 3'd2, 3'd0, 16'hBEEF, 1);
    send(2'b10, 3'd3, 3'd2, 16'h5555, 1);
    send(2'b01, 3'd3, 3'd0, 16'h0, 1);
    drain();
  endtask

  task automatic test_swap();
    int nw = 0;
    logic [5:0] wn = 0;
    send(2'b00, 3'd1, 3'd0, 16'h1234, 1);
    send(2'b00, 3'd2, 3'd0, 16'hBEEF, 1);
    send(2'b11, 3'd1, 3'd2, 16'h0, 1);
    for (int i = 0; i < 6; i++) begin
      if (rf_write) begin
        if (nw < 2) wn = {wn[2:0], rf_writenum};
        nw++;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (nw !== 2 || wn !== {3'd1, 3'd2}) begin
      fails++; $display("FAIL swap_writes got %0d writes nums %o expected 2 writes nums 12", nw, wn);
    end
    send(2'b01, 3'd1, 3'd0, 16'h0, 1);
    send(2'b01, 3'd2, 3'd0, 16'h0, 1);
    send(2'b00, 3'd5, 3'd0, 16'h0F0F, 1);
    send(2'b11, 3'd5, 3'd5, 16'h0, 1);
    send(2'b01, 3'd5, 3'd0, 16'h0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   gap = 0;
    wait_ready();
    cmd_op = 2'b11; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_imm = 16'h0; cmd_valid = 1;
    e.lat = model_cmd(2'b11, 3'd1, 3'd2, 16'h0); e.rd = mrd; sb.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      cmd_op = 2'($urandom); cmd_ra = 3'($urandom); cmd_rb = 3'($urandom);
      cmd_imm = 16'($urandom);
      gap++;
      @(posedge clk); #1;
    end
    tests++;
    if (gap !== 5) begin
      fails++; $display("FAIL b2b_busy_cycles got %0d expected 5", gap);
    end
    cmd_op = 2'b00; cmd_ra = 3'd1; cmd_rb = 3'd4; cmd_imm = 16'h7777;
    e.lat = model_cmd(2'b00, 3'd1, 3'd4, 16'h7777); e.rd = mrd; sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0;
    send(2'b01, 3'd1, 3'd0, 16'h0, 1);
    send(2'b01, 3'd2, 3'd0, 16'h0, 1);
    drain();
  endtask

  task automatic test_reset_mid_swap();
    send(2'b00, 3'd1, 3'd0, 16'h1234, 1);
    send(2'b00, 3'd2, 3'd0, 16'hBEEF, 1);
    drain();
    send(2'b11, 3'd1, 3'd2, 16'h0, 0);
    // only the first half (ra <= old rb) commits before reset
    mrf[1] = 16'hBEEF; mrf[2] = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd2) begin
      fails++; $display("FAIL pre_reset_wr_b got %b/%0d expected 1/2", rf_write, rf_writenum);
    end
    reset = 1; #1;
    tests++;
    if ({rf_write, done, cmd_ready} !== 3'b001) begin
      fails++; $display("FAIL async_reset got %b expected 001", {rf_write, done, cmd_ready});
    end
    #1 reset = 0;
    mrd = 16'h0;
    send(2'b01, 3'd1, 3'd0, 16'h0, 1);
    send(2'b01, 3'd2, 3'd0, 16'h0, 1);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_copy();
    test_swap();
    test_back_to_back();
    test_reset_mid_swap();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

endmodule
